// File: rtl/lsu_unit_if.sv
// Memory-side bus of the load/store unit: word-addressed request channel
// (req/gnt) plus a separate load-response channel (rvalid/rdata).
//   req    : request valid, held until gnt
//   we     : 1 = write, 0 = read
//   addr   : word-aligned byte address
//   be     : byte enables
//   wdata  : lane-replicated store data
//   gnt    : memory accepted the request this cycle
//   rvalid : load data valid
//   rdata  : raw load word
interface lsu_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_unit.sv
// RV32 load/store unit: turns an effective address, funct3 and rs2 into one
// word-wide memory access, and returns extended load data with a status code.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : access request, sampled in IDLE only
//   is_store_i   : 1 = store, 0 = load
//   funct3_i     : RV32I load/store funct3
//   addr_i       : effective byte address
//   wdata_i      : store data (rs2)
//   busy_o       : access in flight
//   done_o       : one-cycle completion pulse
//   err_o        : 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//   rdata_o      : extended load data, valid with done_o
//   mem          : memory bus (master side)
module lsu_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o,
  lsu_unit_if.master  mem
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_TOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q, state_n;
  logic [TO_W-1:0] cnt_q, cnt_n;
  logic            is_store_q, is_store_n;
  logic [2:0]      funct3_q, funct3_n;
  logic [1:0]      off_q, off_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic [1:0]      err_q, err_n;
  logic [DW-1:0]   rdata_q, rdata_n;
  logic            req_q, req_n;
  logic            we_q, we_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic [BW-1:0]   be_q, be_n;
  logic [DW-1:0]   wdata_q, wdata_n;

  // Select the addressed byte/half of the raw word and extend per funct3.
  function automatic logic [DW-1:0] extract(input logic [2:0] f3,
                                            input logic [1:0] off,
                                            input logic [DW-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // Decode of the incoming request in IDLE.
  logic          illegal_c, misaligned_c;
  logic [BW-1:0] st_be_c;
  logic [DW-1:0] st_wdata_c;

  always_comb begin
    if (is_store_i)
      illegal_c = (funct3_i[2] == 1'b1) || (funct3_i[1:0] == 2'b11);
    else
      illegal_c = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    misaligned_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    case (funct3_i[1:0])
      2'b00: begin
        st_be_c    = 4'b0001 << addr_i[1:0];
        st_wdata_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{wdata_i[15:0]}};
      end
      default: begin
        st_be_c    = 4'b1111;
        st_wdata_c = wdata_i;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    is_store_n = is_store_q;
    funct3_n   = funct3_q;
    off_n      = off_q;
    done_n     = 1'b0;
    err_n      = err_q;
    rdata_n    = rdata_q;
    req_n      = 1'b0;
    we_n       = we_q;
    addr_n     = addr_q;
    be_n       = be_q;
    wdata_n    = wdata_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          is_store_n = is_store_i;
          funct3_n   = funct3_i;
          off_n      = addr_i[1:0];
          if (illegal_c || misaligned_c) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = illegal_c ? ERR_ILL : ERR_MIS;
            rdata_n = '0;
          end else begin
            state_n = REQ;
            req_n   = 1'b1;
            we_n    = is_store_i;
            addr_n  = {addr_i[31:2], 2'b00};
            be_n    = is_store_i ? st_be_c : 4'b1111;
            wdata_n = st_wdata_c;
          end
        end
      end
      REQ: begin
        req_n = 1'b1;
        if (mem.gnt) begin
          req_n = 1'b0;
          if (is_store_q) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = ERR_OK;
            rdata_n = '0;
          end else begin
            state_n = WAIT;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt_q + TO_W'(1);
        // rvalid takes priority over the timeout on the boundary cycle
        if (mem.rvalid) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = ERR_OK;
          rdata_n = extract(funct3_q, off_q, mem.rdata);
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = ERR_TOUT;
          rdata_n = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      is_store_q <= is_store_n;
      funct3_q   <= funct3_n;
      off_q      <= off_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      err_q      <= err_n;
      rdata_q    <= rdata_n;
      req_q      <= req_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      be_q       <= be_n;
      wdata_q    <= wdata_n;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.be    = be_q;
  assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: table of accesses with a scripted memory
// responder, plus hand-written reset and reset-dominance sequences.
module tb_lsu_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam int          NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o;

  lsu_unit_if mem ();

  lsu_unit #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .is_store_i (is_store_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gd;        // REQ cycles before gnt
    int          rd;        // WAIT cycles before rvalid (NEVER = none)
    logic [31:0] mrd;       // memory word returned
    logic        poke;      // pulse start_i while busy
    logic        exp_req;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_lat;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gd, input int rd,
                              input logic [31:0] mrd, input logic poke,
                              input logic exp_req, input logic [1:0] exp_err,
                              input logic [31:0] exp_rdata,
                              input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input int exp_lat);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.gd = gd; v.rd = rd;
    v.mrd = mrd; v.poke = poke; v.exp_req = exp_req; v.exp_err = exp_err;
    v.exp_rdata = exp_rdata; v.exp_be = exp_be; v.exp_wd = exp_wd;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  // Entered and left at a negedge with the DUT idle; start is driven at once.
  task automatic run_vec(input int idx, input vec_t v);
    int          c, reqc, w, lat;
    logic        seen_req, granted, unstable, busy_bad, finished;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;
    logic        we0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    c = 0; reqc = 0; w = 0; lat = -1;
    seen_req = 0; granted = 0; unstable = 0; busy_bad = 0; finished = 0;
    a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
    start_i = 1'b1; is_store_i = v.st; funct3_i = v.f3;
    addr_i = v.addr; wdata_i = v.wd;
    for (int k = 0; k < 60 && !finished; k++) begin
      @(negedge clk);
      c++;
      start_i    = v.poke && (c == 2);
      is_store_i = ~v.st;
      funct3_i   = 3'b000;
      addr_i     = 32'hFFFF_FFFD;
      wdata_i    = 32'h0;
      if (!busy_o) busy_bad = 1'b1;
      mem.rvalid = 1'b0;
      mem.rdata  = 32'hBAD0_BAD0;
      if (granted && !v.st) begin
        if (w == v.rd) begin
          mem.rvalid = 1'b1;
          mem.rdata  = v.mrd;
        end
        w++;
      end
      mem.gnt = 1'b0;
      if (mem.req) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          a0 = mem.addr; be0 = mem.be; wd0 = mem.wdata; we0 = mem.we;
        end else if (mem.addr !== a0 || mem.be !== be0 ||
                     mem.wdata !== wd0 || mem.we !== we0) begin
          unstable = 1'b1;
        end
        if (reqc == v.gd) begin
          mem.gnt = 1'b1;
          granted = 1'b1;
        end
        reqc++;
      end
      if (done_o) begin
        finished = 1'b1;
        lat = c;
      end
    end
    start_i = 1'b0; mem.gnt = 1'b0; mem.rvalid = 1'b0;
    chk({tag, " done_seen"}, 32'(finished), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " err"}, 32'(err_o), 32'(v.exp_err));
    if (!v.st && (v.exp_err == 2'b00 || v.exp_err == 2'b11))
      chk({tag, " rdata"}, rdata_o, v.exp_rdata);
    chk({tag, " req_seen"}, 32'(seen_req), 32'(v.exp_req));
    if (v.exp_req) begin
      chk({tag, " mem_addr"}, a0, {v.addr[31:2], 2'b00});
      chk({tag, " mem_be"}, 32'(be0), 32'(v.exp_be));
      chk({tag, " mem_we"}, 32'(we0), 32'(v.st));
      if (v.st) chk({tag, " mem_wdata"}, wd0, v.exp_wd);
      chk({tag, " req_stable"}, 32'(unstable), 32'd0);
    end
    chk({tag, " busy_held"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    chk({tag, " post_idle"}, {29'd0, done_o, busy_o, mem.req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010;
    addr_i = 32'h100; wdata_i = 32'h1;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = 32'h0;

    // Reset dominates a pending start
    repeat (2) @(negedge clk);
    chk("rst busy_done_req_we", {28'd0, busy_o, done_o, mem.req, mem.we}, 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst rdata", rdata_o, 32'd0);
    chk("rst mem_addr", mem.addr, 32'd0);
    chk("rst mem_be", 32'(mem.be), 32'd0);
    chk("rst mem_wdata", mem.wdata, 32'd0);
    start_i = 1'b0;
    rst = 1'b0;

    //          st f3      addr          wd            gd rd     mrd           pk req err rdata         be       wd            lat
    vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0,     32'h0,        0, 1, 0, 32'h0,        4'hF, 32'hDEADBEEF, 2));
    vecs.push_back(mk(1, 3'b000, 32'h103, 32'h000000A5, 0, 0,     32'h0,        0, 1, 0, 32'h0,        4'h8, 32'hA5A5A5A5, 2));
    vecs.push_back(mk(1, 3'b001, 32'h102, 32'h00001234, 0, 0,     32'h0,        0, 1, 0, 32'h0,        4'hC, 32'h12341234, 2));
    vecs.push_back(mk(1, 3'b000, 32'h101, 32'h12345677, 0, 0,     32'h0,        0, 1, 0, 32'h0,        4'h2, 32'h77777777, 2));
    vecs.push_back(mk(1, 3'b010, 32'h104, 32'h0BADF00D, 2, 0,     32'h0,        1, 1, 0, 32'h0,        4'hF, 32'h0BADF00D, 4));
    vecs.push_back(mk(0, 3'b000, 32'h201, 32'h0,        0, 0,     32'h80FF7F01, 0, 1, 0, 32'h0000007F, 4'hF, 32'h0,        3));
    vecs.push_back(mk(0, 3'b100, 32'h201, 32'h0,        0, 0,     32'h80FF7F01, 0, 1, 0, 32'h0000007F, 4'hF, 32'h0,        3));
    vecs.push_back(mk(0, 3'b000, 32'h202, 32'h0,        0, 0,     32'h80FF7F01, 0, 1, 0, 32'hFFFFFFFF, 4'hF, 32'h0,        3));
    vecs.push_back(mk(0, 3'b001, 32'h202, 32'h0,        0, 0,     32'h80FF7F01, 0, 1, 0, 32'hFFFF80FF, 4'hF, 32'h0,        3));
    vecs.push_back(mk(0, 3'b101, 32'h202, 32'h0,        0, 0,     32'h80FF7F01, 0, 1, 0, 32'h000080FF, 4'hF, 32'h0,        3));
    vecs.push_back(mk(0, 3'b010, 32'h200, 32'h0,        0, 0,     32'h80FF7F01, 0, 1, 0, 32'h80FF7F01, 4'hF, 32'h0,        3));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0,        0, 0,     32'h0,        0, 0, 1, 32'h0,        4'h0, 32'h0,        1));
    vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0,        0, 0,     32'h0,        0, 0, 2, 32'h0,        4'h0, 32'h0,        1));
    vecs.push_back(mk(1, 3'b100, 32'h100, 32'h0,        0, 0,     32'h0,        0, 0, 2, 32'h0,        4'h0, 32'h0,        1));
    vecs.push_back(mk(1, 3'b001, 32'h101, 32'h0,        0, 0,     32'h0,        0, 0, 1, 32'h0,        4'h0, 32'h0,        1));
    vecs.push_back(mk(0, 3'b010, 32'h300, 32'h0,        3, 5,     32'h12345678, 1, 1, 0, 32'h12345678, 4'hF, 32'h0,        11));
    vecs.push_back(mk(0, 3'b010, 32'h304, 32'h0,        0, NEVER, 32'h0,        0, 1, 3, 32'h0,        4'hF, 32'h0,        18));
    vecs.push_back(mk(0, 3'b001, 32'h306, 32'h0,        0, 15,    32'h80010000, 0, 1, 0, 32'hFFFF8001, 4'hF, 32'h0,        18));

    // Consecutive vectors start in the first idle cycle after each done
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset while waiting for load data; a late rvalid must be ignored
    start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h400; wdata_i = 32'h0;
    @(negedge clk);
    start_i = 1'b0;
    chk("rstwait req", 32'(mem.req), 32'd1);
    mem.gnt = 1'b1;
    @(negedge clk);
    mem.gnt = 1'b0;
    chk("rstwait in_wait", {30'd0, busy_o, mem.req}, 32'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait idle", {29'd0, busy_o, done_o, mem.req}, 32'd0);
    mem.rvalid = 1'b1; mem.rdata = 32'h55AA55AA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("late_rvalid%0d", k), {30'd0, busy_o, done_o}, 32'd0);
    end
    mem.rvalid = 1'b0;
    chk("late_rvalid rdata", rdata_o, 32'd0);

    // Unit still usable after the aborted access
    run_vec(99, mk(0, 3'b100, 32'h503, 32'h0, 1, 1, 32'hC3000000, 0, 1, 0,
                   32'h000000C3, 4'hF, 32'h0, 5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
